// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding,
// iteration constants and common enable levels.
package div_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Machine word width used across the datapath.
  localparam int WORD_DATA_W = 32;

  // Number of restoring iterations for a full word divide.
  localparam int DIV_ITER_NUM = 32;

  // Iteration counter width (holds 0..DIV_ITER_NUM).
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_RUN  = 2'd1,
    DIV_STATE_FIN  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One combinational radix-2 restoring iteration: shift {rem, quo} left by
// one, trial-subtract the divisor from the widened remainder and keep the
// difference only when it is non-negative.
module div_unit_step
  import div_unit_pkg::*;
#(
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  // The remainder is always below the divisor, so a DATA_W+1 wide trial
  // subtraction is enough: its top bit is set exactly when it went negative.
  assign rem_sh = {rem_i, quo_i[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, divisor_i};

  assign rem_o = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle integer divider (radix-2 restoring, DATA_W iterations).
// Optional signed support is built when DIV_SIGNED_EN is defined; without
// it every divide is unsigned, `of` is tied low and latency is unchanged.
//
// Handshake: `start` is a request that is accepted only in IDLE (busy low)
// with `flush` low; there is no back-pressure on results -- `done` is a
// one-cycle valid for quotient/remainder/dz/of, which then hold until the
// next completed divide or reset.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = WORD_DATA_W
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic              flush,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              dz,
  output logic              of,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvsr_q;
  logic [DATA_W-1:0] rem_nx, quo_nx;
  logic [DATA_W-1:0] dvd_cap, dvs_cap;
  logic [DATA_W-1:0] q_mag, q_fin, r_fin;
  logic [DATA_W-1:0] quotient_q, remainder_q;
  logic              dz_flag_q, of_flag_q, ovf_cond;
  logic              done_q, dz_q, of_q;
  logic              accept, finish;

  assign accept = (state_q == DIV_STATE_IDLE) && start && !flush;
  assign finish = (state_q == DIV_STATE_FIN) && !flush;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;

  // Signed operands are captured as magnitudes; |MIN| stays 0x80..0 unsigned.
  assign dvd_cap  = (sign && dividend[DATA_W-1]) ? -dividend : dividend;
  assign dvs_cap  = (sign && divisor[DATA_W-1])  ? -divisor  : divisor;
  assign ovf_cond = sign && (dividend == {1'b1, {(DATA_W-1){1'b0}}}) &&
                    (divisor == {DATA_W{1'b1}});

  // Result sign flags, latched with the operands.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      neg_q_q <= DISABLE;
      neg_r_q <= DISABLE;
    end else if (accept) begin
      neg_q_q <= sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_r_q <= sign & dividend[DATA_W-1];
    end
  end

  assign q_mag = neg_q_q ? -quo_q : quo_q;
  assign r_fin = neg_r_q ? -rem_q : rem_q;
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign dvd_cap     = dividend;
  assign dvs_cap     = divisor;
  assign ovf_cond    = DISABLE;
  assign q_mag       = quo_q;
  assign r_fin       = rem_q;
`endif

  // A zero divisor always reports all-ones, whatever the operand signs.
  assign q_fin = dz_flag_q ? {DATA_W{1'b1}} : q_mag;

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state_q <= DIV_STATE_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: flush cancels any active divide.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_STATE_IDLE: if (accept) state_d = DIV_STATE_RUN;
      DIV_STATE_RUN: begin
        if (flush)                  state_d = DIV_STATE_IDLE;
        else if (cnt_q == LAST_ITER) state_d = DIV_STATE_FIN;
      end
      DIV_STATE_FIN:  state_d = DIV_STATE_IDLE;
      default:        state_d = DIV_STATE_IDLE;
    endcase
  end

  // Iteration datapath: capture on accept, one restoring step per RUN cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      dz_flag_q <= DISABLE;
      of_flag_q <= DISABLE;
    end else if (accept) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= dvd_cap;
      dvsr_q    <= dvs_cap;
      dz_flag_q <= (divisor == '0);
      of_flag_q <= ovf_cond;
    end else if (state_q == DIV_STATE_RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  // Result registers: updated only when a divide completes unflushed.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      done_q      <= DISABLE;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= DISABLE;
      of_q        <= DISABLE;
    end else begin
      done_q <= finish;
      if (finish) begin
        quotient_q  <= q_fin;
        remainder_q <= r_fin;
        dz_q        <= dz_flag_q;
        of_q        <= of_flag_q;
      end
    end
  end

  assign busy        = (state_q != DIV_STATE_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign dz          = dz_q;
  assign of          = of_q;
  assign dbg_state_o = state_q;

endmodule
